// File: rtl/kf8259_init_sequencer.sv
// Purpose: 8259-style command sequencer. It runs the ICW1..ICW4 initialization
//          sequence and decodes the OCW1/OCW2/OCW3 operation words into the
//          mode, mask and command outputs.
// Latency: an accepted write updates the outputs on the clock edge that ends
//          the acceptance cycle (1 cycle).
// Backpressure: none. A strobe may be held for several cycles, but only its
//               first high cycle after a low cycle is accepted.
//
// Ports:
//   clock, reset                       sole clock, synchronous active-high reset
//   internal_data_bus[7:0]             write data (zero when idle)
//   write_initial_command_word_1       ICW1 strobe
//   write_initial_command_word_2_to_4  odd-address strobe (ICW2/3/4 during init)
//   write_operation_control_word_1     odd-address strobe (OCW1 when ready)
//   write_operation_control_word_2/3   OCW2 / OCW3 strobes
//   init_busy .. reinit_pulse          registered mode/command outputs
//
// Build option: define KF8259_CASCADE_EN to latch ICW3 into cascade_config and
// to report the real SNGL bit. Without it, the block is single-chip only:
// cascade_config reads 0x00 and single_mode reads 1.
module kf8259_init_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] internal_data_bus,
  input  logic       write_initial_command_word_1,
  input  logic       write_initial_command_word_2_to_4,
  input  logic       write_operation_control_word_1,
  input  logic       write_operation_control_word_2,
  input  logic       write_operation_control_word_3,
  output logic       init_busy,
  output logic       level_triggered,
  output logic       single_mode,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_config,
  output logic [4:0] icw4_mode,
  output logic [7:0] interrupt_mask,
  output logic       eoi_pulse,
  output logic       eoi_specific,
  output logic [2:0] eoi_level,
  output logic       rotate_pulse,
  output logic       auto_rotate_mode,
  output logic [2:0] lowest_priority,
  output logic       special_mask_mode,
  output logic       read_isr_select,
  output logic       poll_pulse,
  output logic       reinit_pulse
);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_ICW2  = 2'd1,
    S_ICW3  = 2'd2,
    S_ICW4  = 2'd3
  } state_t;

  state_t     state_q;
  logic       armed_q;      // 1 when every strobe was low in the previous cycle
  logic       busy_q;
  logic       ic4_q;
  logic       sngl_q;
  logic       ltim_q;
  logic [4:0] vb_q;
  logic [4:0] icw4_q;
  logic [7:0] imr_q;
  logic       eoi_q;
  logic       eoi_spec_q;
  logic [2:0] eoi_lvl_q;
  logic       rot_q;
  logic       arot_q;
  logic [2:0] lp_q;
  logic       smm_q;
  logic       risr_q;
  logic       poll_q;
  logic       reinit_q;
`ifdef KF8259_CASCADE_EN
  logic [7:0] cas_q;
`endif

  logic       strobe_any;
  logic       accept;
  logic       odd_wr;
  logic [7:0] d;

  assign d          = internal_data_bus;
  assign strobe_any = write_initial_command_word_1 | write_initial_command_word_2_to_4 |
                      write_operation_control_word_1 | write_operation_control_word_2 |
                      write_operation_control_word_3;
  // armed_q is cleared by reset, so a strobe held through reset release is
  // ignored until it has dropped low at least once.
  assign accept     = strobe_any & armed_q;
  assign odd_wr     = write_initial_command_word_2_to_4 | write_operation_control_word_1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_READY;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      ic4_q      <= 1'b0;
      sngl_q     <= 1'b0;
      ltim_q     <= 1'b0;
      vb_q       <= 5'd0;
      icw4_q     <= 5'd0;
      imr_q      <= 8'h00;
      eoi_q      <= 1'b0;
      eoi_spec_q <= 1'b0;
      eoi_lvl_q  <= 3'd0;
      rot_q      <= 1'b0;
      arot_q     <= 1'b0;
      lp_q       <= 3'd7;
      smm_q      <= 1'b0;
      risr_q     <= 1'b0;
      poll_q     <= 1'b0;
      reinit_q   <= 1'b0;
`ifdef KF8259_CASCADE_EN
      cas_q      <= 8'h00;
`endif
    end else begin
      armed_q  <= ~strobe_any;
      // Command pulses last for exactly one cycle.
      eoi_q    <= 1'b0;
      rot_q    <= 1'b0;
      poll_q   <= 1'b0;
      reinit_q <= 1'b0;

      if (accept) begin
        if (write_initial_command_word_1) begin
          // ICW1 restarts initialization from any state.
          state_q  <= S_ICW2;
          busy_q   <= 1'b1;
          ic4_q    <= d[0];
          sngl_q   <= d[1];
          ltim_q   <= d[3];
          imr_q    <= 8'h00;
          lp_q     <= 3'd7;
          smm_q    <= 1'b0;
          risr_q   <= 1'b0;
          arot_q   <= 1'b0;
          reinit_q <= 1'b1;
          if (!d[0]) begin
            icw4_q <= 5'd0;
          end
        end else if (odd_wr) begin
          case (state_q)
            S_ICW2: begin
              vb_q <= d[7:3];
              if (!sngl_q) begin
                state_q <= S_ICW3;
              end else if (ic4_q) begin
                state_q <= S_ICW4;
              end else begin
                state_q <= S_READY;
                busy_q  <= 1'b0;
              end
            end
            S_ICW3: begin
              // In a single-chip build the ICW3 slot is still consumed,
              // but its data is dropped.
`ifdef KF8259_CASCADE_EN
              cas_q <= d;
`endif
              if (ic4_q) begin
                state_q <= S_ICW4;
              end else begin
                state_q <= S_READY;
                busy_q  <= 1'b0;
              end
            end
            S_ICW4: begin
              icw4_q  <= d[4:0];
              state_q <= S_READY;
              busy_q  <= 1'b0;
            end
            default: begin
              // S_READY: an odd-address write is OCW1.
              imr_q <= d;
            end
          endcase
        end else if (!busy_q) begin
          if (write_operation_control_word_2) begin
            // The command is selected by D7:5 = {R, SL, EOI}.
            case (d[7:5])
              3'b001: begin
                eoi_q      <= 1'b1;
                eoi_spec_q <= 1'b0;
              end
              3'b011: begin
                eoi_q      <= 1'b1;
                eoi_spec_q <= 1'b1;
                eoi_lvl_q  <= d[2:0];
              end
              3'b101: begin
                eoi_q      <= 1'b1;
                eoi_spec_q <= 1'b0;
                rot_q      <= 1'b1;
              end
              3'b111: begin
                eoi_q      <= 1'b1;
                eoi_spec_q <= 1'b1;
                eoi_lvl_q  <= d[2:0];
                rot_q      <= 1'b1;
              end
              3'b100:  arot_q <= 1'b1;
              3'b000:  arot_q <= 1'b0;
              3'b110:  lp_q   <= d[2:0];
              default: ;  // 010: no operation
            endcase
          end
          if (write_operation_control_word_3) begin
            if (d[1]) risr_q <= d[0];
            if (d[6]) smm_q  <= d[5];
            if (d[2]) poll_q <= 1'b1;
          end
        end
      end
    end
  end

  assign init_busy         = busy_q;
  assign level_triggered   = ltim_q;
  assign vector_base       = vb_q;
  assign icw4_mode         = icw4_q;
  assign interrupt_mask    = imr_q;
  assign eoi_pulse         = eoi_q;
  assign eoi_specific      = eoi_spec_q;
  assign eoi_level         = eoi_lvl_q;
  assign rotate_pulse      = rot_q;
  assign auto_rotate_mode  = arot_q;
  assign lowest_priority   = lp_q;
  assign special_mask_mode = smm_q;
  assign read_isr_select   = risr_q;
  assign poll_pulse        = poll_q;
  assign reinit_pulse      = reinit_q;
`ifdef KF8259_CASCADE_EN
  assign cascade_config    = cas_q;
  assign single_mode       = sngl_q;
`else
  assign cascade_config    = 8'h00;
  assign single_mode       = 1'b1;
`endif

endmodule

// File: tb/tb_kf8259_init_sequencer.sv
// Bench for kf8259_init_sequencer: table of directed write vectors with full
// hand-computed output snapshots, followed by multi-cycle sequences for held
// strobes and for a strobe held through reset release.
module tb_kf8259_init_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] internal_data_bus;
  logic       w_icw1, w_icw234, w_ocw1, w_ocw2, w_ocw3;

  logic       init_busy, level_triggered, single_mode;
  logic [4:0] vector_base, icw4_mode;
  logic [7:0] cascade_config, interrupt_mask;
  logic       eoi_pulse, eoi_specific, rotate_pulse, auto_rotate_mode;
  logic [2:0] eoi_level, lowest_priority;
  logic       special_mask_mode, read_isr_select, poll_pulse, reinit_pulse;

  always #5 clock = ~clock;

  kf8259_init_sequencer dut (
    .clock                             (clock),
    .reset                             (reset),
    .internal_data_bus                 (internal_data_bus),
    .write_initial_command_word_1      (w_icw1),
    .write_initial_command_word_2_to_4 (w_icw234),
    .write_operation_control_word_1    (w_ocw1),
    .write_operation_control_word_2    (w_ocw2),
    .write_operation_control_word_3    (w_ocw3),
    .init_busy                         (init_busy),
    .level_triggered                   (level_triggered),
    .single_mode                       (single_mode),
    .vector_base                       (vector_base),
    .cascade_config                    (cascade_config),
    .icw4_mode                         (icw4_mode),
    .interrupt_mask                    (interrupt_mask),
    .eoi_pulse                         (eoi_pulse),
    .eoi_specific                      (eoi_specific),
    .eoi_level                         (eoi_level),
    .rotate_pulse                      (rotate_pulse),
    .auto_rotate_mode                  (auto_rotate_mode),
    .lowest_priority                   (lowest_priority),
    .special_mask_mode                 (special_mask_mode),
    .read_isr_select                   (read_isr_select),
    .poll_pulse                        (poll_pulse),
    .reinit_pulse                      (reinit_pulse)
  );

`ifdef KF8259_CASCADE_EN
  localparam bit CAS_EN = 1'b1;
`else
  localparam bit CAS_EN = 1'b0;
`endif

  // Strobe order: {icw1, icw2_to_4, ocw1, ocw2, ocw3}
  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] ICW1 = 5'b10000;
  localparam logic [4:0] ODD  = 5'b01100;
  localparam logic [4:0] OCW2 = 5'b00010;
  localparam logic [4:0] OCW3 = 5'b00001;

  typedef struct packed {
    logic       busy;
    logic       ltim;
    logic       sngl;
    logic [4:0] vb;
    logic [7:0] cas;
    logic [4:0] icw4;
    logic [7:0] imr;
    logic       eoi;
    logic       es;
    logic [2:0] el;
    logic       rot;
    logic       arot;
    logic [2:0] lp;
    logic       smm;
    logic       risr;
    logic       poll;
    logic       reinit;
  } obs_t;

  typedef struct {
    logic [4:0] stb;
    logic [7:0] dat;
    obs_t       exp;
  } vec_t;

  obs_t obs;
  obs_t e;
  obs_t rst_exp;
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  assign obs = {init_busy, level_triggered, single_mode, vector_base, cascade_config,
                icw4_mode, interrupt_mask, eoi_pulse, eoi_specific, eoi_level,
                rotate_pulse, auto_rotate_mode, lowest_priority, special_mask_mode,
                read_isr_select, poll_pulse, reinit_pulse};

  // A single-chip build reports SNGL=1 and never shows an ICW3 value.
  function automatic obs_t adjust(input obs_t x);
    obs_t y = x;
    if (!CAS_EN) begin
      y.sngl = 1'b1;
      y.cas  = 8'h00;
    end
    return y;
  endfunction

  function automatic obs_t no_pulses(input obs_t x);
    obs_t y = x;
    y.eoi = 1'b0; y.rot = 1'b0; y.poll = 1'b0; y.reinit = 1'b0;
    return y;
  endfunction

  task automatic check(input string name, input obs_t want_raw);
    obs_t want = adjust(want_raw);
    n_vec++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: outputs got %h expected %h", name, obs, want);
    end
  endtask

  task automatic check_val(input string name, input int unsigned got, input int unsigned want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic drive(input logic [4:0] s, input logic [7:0] dv);
    {w_icw1, w_icw234, w_ocw1, w_ocw2, w_ocw3} = s;
    internal_data_bus = dv;
  endtask

  task automatic add(input logic [4:0] s, input logic [7:0] dv, input obs_t x);
    vec_t v;
    v.stb = s; v.dat = dv; v.exp = x;
    tbl.push_back(v);
  endtask

  initial begin
    int cnt;

    rst_exp    = '0;
    rst_exp.lp = 3'd7;

    // ---- vector table: e is the running expected snapshot ----
    e = rst_exp;
    e = no_pulses(e); e.busy = 1; e.sngl = 1; e.reinit = 1;      add(ICW1, 8'h13, e); // IC4=1 SNGL=1
    e = no_pulses(e); e.vb = 5'h01;                              add(ODD,  8'h08, e); // ICW2 -> ICW4
    e = no_pulses(e); e.icw4 = 5'h03; e.busy = 0;                add(ODD,  8'h03, e); // ICW4 -> READY
    e = no_pulses(e); e.imr = 8'h5A;                             add(ODD,  8'h5A, e); // OCW1
    e = no_pulses(e); e.eoi = 1; e.es = 1; e.el = 3;             add(OCW2, 8'h63, e); // specific EOI
    e = no_pulses(e); e.lp = 3'd5;                               add(OCW2, 8'hC5, e); // set priority
    e = no_pulses(e); e.eoi = 1; e.es = 0;                       add(OCW2, 8'h20, e); // non-specific EOI
    e = no_pulses(e); e.eoi = 1; e.rot = 1;                      add(OCW2, 8'hA0, e); // rotate on EOI
    e = no_pulses(e); e.eoi = 1; e.rot = 1; e.es = 1; e.el = 6;  add(OCW2, 8'hE6, e); // specific rotate
    e = no_pulses(e); e.arot = 1;                                add(OCW2, 8'h80, e);
    e = no_pulses(e);                                            add(OCW2, 8'h40, e); // no-op
    e = no_pulses(e); e.arot = 0;                                add(OCW2, 8'h00, e);
    e = no_pulses(e); e.risr = 1;                                add(OCW3, 8'h0B, e);
    e = no_pulses(e); e.smm = 1; e.poll = 1;                     add(OCW3, 8'h6C, e);
    e = no_pulses(e); e.smm = 0; e.risr = 0;                     add(OCW3, 8'h4A, e);
    e = no_pulses(e); e.risr = 1; e.poll = 1;                    add(OCW3, 8'h0F, e);
    // LTIM=1, SNGL=0, IC4=0: icw4_mode cleared, mode state reset
    e = no_pulses(e); e.busy = 1; e.ltim = 1; e.sngl = 0; e.icw4 = 0; e.imr = 0;
    e.arot = 0; e.lp = 3'd7; e.smm = 0; e.risr = 0; e.reinit = 1; add(ICW1, 8'h18, e);
    e = no_pulses(e);                                            add(OCW3, 8'h0B, e); // ignored while busy
    e = no_pulses(e);                                            add(OCW2, 8'h80, e); // ignored while busy
    e = no_pulses(e); e.vb = 5'h04;                              add(ODD,  8'h20, e); // ICW2 -> ICW3
    e = no_pulses(e); e.cas = 8'h04; e.busy = 0;                 add(ODD,  8'h04, e); // ICW3 -> READY
    e = no_pulses(e); e.imr = 8'h77;                             add(ODD,  8'h77, e);
    // restart from the ICW3 state
    e = no_pulses(e); e.busy = 1; e.ltim = 0; e.imr = 0; e.reinit = 1; add(ICW1, 8'h11, e);
    e = no_pulses(e); e.vb = 5'h04;                              add(ODD,  8'h20, e); // -> ICW3
    e = no_pulses(e); e.reinit = 1;                              add(ICW1, 8'h11, e); // back to ICW2
    e = no_pulses(e);                                            add(OCW3, 8'h0B, e); // ignored
    e = no_pulses(e); e.vb = 5'h05;                              add(ODD,  8'h28, e); // ICW2 again
    e = no_pulses(e); e.cas = 8'h08;                             add(ODD,  8'h08, e); // ICW3 -> ICW4
    e = no_pulses(e); e.icw4 = 5'h01; e.busy = 0;                add(ODD,  8'h01, e);
    e = no_pulses(e); e.imr = 8'hC3;                             add(ODD,  8'hC3, e);
    // full cascade sequence
    e = no_pulses(e); e.busy = 1; e.imr = 0; e.reinit = 1;       add(ICW1, 8'h11, e);
    e = no_pulses(e); e.vb = 5'h04;                              add(ODD,  8'h20, e);
    e = no_pulses(e); e.cas = 8'h04;                             add(ODD,  8'h04, e);
    e = no_pulses(e); e.icw4 = 5'h01; e.busy = 0;                add(ODD,  8'h01, e);
    e = no_pulses(e); e.imr = 8'hC3;                             add(ODD,  8'hC3, e);

    // ---- reset ----
    drive(IDLE, 8'h00);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    check("reset_state", rst_exp);

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock) drive(tbl[i].stb, tbl[i].dat);
      @(posedge clock); #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
      @(negedge clock) drive(IDLE, 8'h00);
      @(posedge clock); #1;
      check($sformatf("vec%0d_pulse_end", i), no_pulses(tbl[i].exp));
    end

    // ---- OCW1 held 4 cycles: accepted once ----
    @(negedge clock) drive(ODD, 8'hFB);
    repeat (4) @(posedge clock);
    #1 check_val("held_ocw1_mask", interrupt_mask, 8'hFB);
    @(negedge clock) drive(IDLE, 8'h00);
    @(posedge clock);

    // held strobe with data changing after the first cycle
    @(negedge clock) drive(ODD, 8'h3C);
    @(posedge clock);
    @(negedge clock) drive(ODD, 8'h00);
    repeat (3) @(posedge clock);
    #1 check_val("held_ocw1_late_data", interrupt_mask, 8'h3C);
    @(negedge clock) drive(IDLE, 8'h00);
    @(posedge clock);

    // ---- OCW2 held 4 cycles: one eoi pulse ----
    cnt = 0;
    @(negedge clock) drive(OCW2, 8'h20);
    repeat (4) begin
      @(posedge clock); #1;
      cnt += int'(eoi_pulse);
    end
    @(negedge clock) drive(IDLE, 8'h00);
    @(posedge clock); #1;
    cnt += int'(eoi_pulse);
    check_val("held_ocw2_eoi_count", cnt, 1);

    // ---- strobe held through reset release ----
    @(negedge clock) begin
      drive(ODD, 8'h99);
      reset = 1'b1;
    end
    @(posedge clock); #1;
    check("reset_overrides_strobe", rst_exp);
    @(negedge clock) reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_val("held_through_reset_ignored", interrupt_mask, 8'h00);
    @(negedge clock) drive(IDLE, 8'h00);
    @(posedge clock);
    @(negedge clock) drive(ODD, 8'h99);
    @(posedge clock); #1;
    check_val("accept_after_release", interrupt_mask, 8'h99);
    @(negedge clock) drive(IDLE, 8'h00);
    @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
